mii_packet_tx: RTL and testbench
================================

Name: mii_packet_tx

Overview:
Transmit-side counterpart of the receive packet store. Pops packet lengths from a show-ahead length FIFO and reads bytes from the packet register file. Emits each packet as an MII-style byte-wide frame: 7 preamble bytes, SFD, payload, then an enforced inter-frame gap. Sits between the packet buffer and the PHY transmit interface.

Parameters:
pDATA_WIDTH, 8, data byte width (fixed at 8 when the FCS feature is enabled)
pDEPTH_RAM, 2048, packet register-file depth in entries; need not be a power of two
pPREAMBLE_LEN, 7, number of 0x55 bytes before the SFD
pIFG_LEN, 12, minimum idle cycles after each frame
Derived: AW = $clog2(pDEPTH_RAM)

Ports:
iclk  in  1  clock; all logic on the rising edge
i_rst  in  1  synchronous, active-high reset
i_tx_enable  in  1  permits a new frame to start; sampled only in IDLE
i_abort  in  1  terminates the frame in flight
i_len  in  AW  head of the length FIFO (show-ahead, valid when !i_len_empty)
i_len_empty  in  1  length FIFO empty
o_len_rd  out  1  FIFO pop; combinational, one cycle per length consumed
o_rd_addr  out  AW  register-file read address (registered read pointer)
i_rd_data  in  pDATA_WIDTH  register-file data; combinational read of o_rd_addr
otx_en  out  1  transmit enable (registered)
otx_d  out  pDATA_WIDTH  transmit byte (registered)
o_busy  out  1  high in any state other than IDLE
o_pkt_done  out  1  one-cycle pulse on the first cycle otx_en is low after a frame

Behaviour:
- Reset, synchronous: state=IDLE; otx_en=0; otx_d=0; o_rd_addr=0; o_pkt_done=0; o_busy=0; o_len_rd forced to 0 during reset. Reset mid-frame drops otx_en on the next edge and discards the remaining packet. The read pointer returns to 0, so the writer must also be reset.
- FSM states: IDLE, PREAMBLE, SFD, DATA, [FCS], IFG.
- IDLE: when i_tx_enable & !i_len_empty, assert o_len_rd combinationally and latch i_len into the byte counter on the same edge.
  - Length 0: entry is popped and discarded; stay in IDLE; pointer unchanged; no o_pkt_done.
  - Length nonzero: go to PREAMBLE.
- Timing, with the pop in cycle N and length L:
  - otx_d=0x55 on cycles N+1..N+pPREAMBLE_LEN.
  - SFD 0xD5 on cycle N+pPREAMBLE_LEN+1.
  - Payload bytes on the next L cycles; otx_en=1 throughout.
- Read: o_rd_addr holds the address of byte k one cycle before byte k appears on otx_d. The pointer increments once per payload byte. It wraps from pDEPTH_RAM-1 to 0, so no power-of-two assumption is made.
- After the final byte, the pointer equals start+L mod pDEPTH_RAM. Packets are contiguous, and the next packet starts there.
- IFG: after the last byte at cycle T, otx_en=0 for cycles T+1..T+pIFG_LEN; o_pkt_done=1 at T+1. The state is IDLE at T+pIFG_LEN+1, so the minimum gap between frames is pIFG_LEN+1 cycles.
- Abort: i_abort high while otx_en=1 gives otx_en=0 on the next cycle, the pointer jumps to start+L mod depth, o_pkt_done pulses, then a full IFG. i_abort is ignored in IDLE and IFG.
- Simultaneous events: abort takes priority over the normal last-byte transition. i_tx_enable low does not stop a frame already started.
- Pointer and length arithmetic is AW bits wide, modulo pDEPTH_RAM.

Optional Feature:
Macro PKT_TX_FCS_EN.
- Defined: a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) is computed over the payload bytes. FCS state sends 4 FCS bytes, LSB first, directly after the payload with otx_en=1. Timing is shifted by 4 cycles; an abort suppresses the FCS.
- Undefined: no FCS state or CRC logic; the frame ends after the payload.

Decomposition:
- Package mii_tx_pkg: FSM state encoding, preamble byte 0x55, SFD 0xD5, CRC-32 polynomial/init/final-XOR constants.
- One sub-module, crc32_d8: byte-wide combinational next-CRC function with a registered accumulator, instantiated only under PKT_TX_FCS_EN.

Test Plan:
1. Memory 0..3 = 11 22 33 44, FIFO={4}, enable=1 -> pop at N; otx: 7x55, D5, 11 22 33 44; otx_en low at N+13 with o_pkt_done=1; pointer=4.
2. FIFO={3,5} -> second frame reads addresses 3..7; exactly pIFG_LEN+1=13 otx_en-low cycles between frames.
3. pDEPTH_RAM=16, pointer=14, L=4 -> o_rd_addr 14,15,0,1; final pointer=2.
4. L=10 from address 0, i_abort on the 2nd payload byte -> otx_en=0 next cycle; pointer=10; o_pkt_done pulse; next packet starts at address 10 after the IFG.
5. FIFO={0,1} -> zero entry popped with no otx_en activity; 1-byte frame follows immediately; i_rst asserted mid-preamble -> otx_en=0 next cycle, all outputs at reset values.
6. With PKT_TX_FCS_EN, payload 31..39 ("123456789") -> FCS bytes 26 39 F4 CB follow the payload, then otx_en low.

Source files
------------

// File: rtl/mii_packet_tx_pkg.sv
// mii_tx_pkg: FSM encoding plus framing and CRC-32 constants shared by mii_packet_tx.
// The FCS state exists only when PKT_TX_FCS_EN is defined.
package mii_tx_pkg;
`ifdef PKT_TX_FCS_EN
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, FCS, IFG} state_e;
`else
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, IFG} state_e;
`endif
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOR       = 32'hFFFFFFFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        for (int i = 0; i < 32; i++) bitrev32[i] = x[31-i];
    endfunction
endpackage

// File: rtl/mii_packet_tx_crc32_d8.sv
// crc32_d8: reflected CRC-32 accumulator, one byte per enabled cycle.
// crc_o already carries the final XOR, so its low byte is the first FCS byte.
module crc32_d8
    import mii_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  d_i,
    output logic [31:0] crc_o
);
    localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

    logic [31:0] crc_q, crc_d, nxt;

    always_comb begin
        nxt = crc_q ^ {24'b0, d_i};
        for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ POLY_R : nxt >> 1;
        crc_d = init_i ? CRC_INIT : en_i ? nxt : crc_q;
    end

    always_ff @(posedge clk) crc_q <= rst ? CRC_INIT : crc_d;

    assign crc_o = crc_q ^ CRC_XOR;
endmodule

// File: rtl/mii_packet_tx.sv
// mii_packet_tx: pops lengths, reads the packet store, emits preamble/SFD/payload then an IFG.
// Define PKT_TX_FCS_EN to append a CRC-32 FCS after the payload.
module mii_packet_tx
    import mii_tx_pkg::*;
#(
    parameter  int pDATA_WIDTH   = 8,
    parameter  int pDEPTH_RAM    = 2048,
    parameter  int pPREAMBLE_LEN = 7,
    parameter  int pIFG_LEN      = 12,
    localparam int AW            = $clog2(pDEPTH_RAM)
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   i_tx_enable,
    input  logic                   i_abort,
    input  logic [AW-1:0]          i_len,
    input  logic                   i_len_empty,
    output logic                   o_len_rd,
    output logic [AW-1:0]          o_rd_addr,
    input  logic [pDATA_WIDTH-1:0] i_rd_data,
    output logic                   otx_en,
    output logic [pDATA_WIDTH-1:0] otx_d,
    output logic                   o_busy,
    output logic                   o_pkt_done
);
    localparam int CW = 16;
    localparam logic [AW:0] DEPTH = (AW+1)'(pDEPTH_RAM);

    state_e                 state_q, state_d;
    logic [AW-1:0]          len_q, len_d, ptr_q, ptr_d, end_q, end_d, ptr_inc;
    logic [CW-1:0]          ph_q, ph_d;
    logic                   en_q, en_d, done_q, done_d, len_rd;
    logic [pDATA_WIDTH-1:0] txd_q, txd_d;
    logic [AW:0]            sum;
`ifdef PKT_TX_FCS_EN
    logic                   crc_init, crc_en;
    logic [31:0]            fcs;

    crc32_d8 u_crc (
        .clk(iclk), .rst(i_rst), .init_i(crc_init), .en_i(crc_en), .d_i(i_rd_data), .crc_o(fcs)
    );
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        ph_d    = ph_q;
        en_d    = en_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        len_rd  = 1'b0;
`ifdef PKT_TX_FCS_EN
        crc_init = 1'b0;
        crc_en   = 1'b0;
`endif
        sum     = {1'b0, ptr_q} + {1'b0, i_len};
        ptr_inc = (ptr_q == AW'(pDEPTH_RAM - 1)) ? '0 : ptr_q + 1'b1;
        case (state_q)
            IDLE: if (i_tx_enable && !i_len_empty) begin
                len_rd = 1'b1;
                len_d  = i_len;
                end_d  = (sum >= DEPTH) ? AW'(sum - DEPTH) : AW'(sum);
`ifdef PKT_TX_FCS_EN
                crc_init = 1'b1;
`endif
                if (i_len != '0) begin
                    state_d = PREAMBLE;
                    en_d    = 1'b1;
                    txd_d   = pDATA_WIDTH'(PREAMBLE_BYTE);
                    ph_d    = CW'(1);
                end
            end
            PREAMBLE: if (ph_q == CW'(pPREAMBLE_LEN)) begin
                state_d = SFD;
                txd_d   = pDATA_WIDTH'(SFD_BYTE);
            end else begin
                ph_d  = ph_q + 1'b1;
                txd_d = pDATA_WIDTH'(PREAMBLE_BYTE);
            end
            SFD, DATA: if (state_q == SFD || len_q != '0) begin
                state_d = DATA;
                txd_d   = i_rd_data;
                ptr_d   = ptr_inc;
                len_d   = len_q - 1'b1;
`ifdef PKT_TX_FCS_EN
                crc_en  = 1'b1;
`endif
            end else begin
`ifdef PKT_TX_FCS_EN
                state_d = FCS;
                txd_d   = pDATA_WIDTH'(fcs[7:0]);
                ph_d    = CW'(1);
`else
                state_d = IFG;
                en_d    = 1'b0;
                done_d  = 1'b1;
                txd_d   = '0;
                ph_d    = CW'(1);
`endif
            end
`ifdef PKT_TX_FCS_EN
            FCS: if (ph_q == CW'(4)) begin
                state_d = IFG;
                en_d    = 1'b0;
                done_d  = 1'b1;
                txd_d   = '0;
                ph_d    = CW'(1);
            end else begin
                txd_d = pDATA_WIDTH'(fcs >> {ph_q[1:0], 3'b000});
                ph_d  = ph_q + 1'b1;
            end
`endif
            IFG: if (ph_q == CW'(pIFG_LEN)) state_d = IDLE; else ph_d = ph_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including the last-byte transition.
        if (en_q && i_abort) begin
            state_d = IFG;
            en_d    = 1'b0;
            done_d  = 1'b1;
            txd_d   = '0;
            ph_d    = CW'(1);
            ptr_d   = end_q;
        end
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            end_q   <= '0;
            ph_q    <= '0;
            en_q    <= 1'b0;
            txd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            ph_q    <= ph_d;
            en_q    <= en_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign o_len_rd   = len_rd & ~i_rst;
    assign o_rd_addr  = ptr_q;
    assign otx_en     = en_q;
    assign otx_d      = txd_q;
    assign o_busy     = state_q != IDLE;
    assign o_pkt_done = done_q;
endmodule

// File: tb/tb_mii_packet_tx.sv
// tb_mii_packet_tx: directed frame checks on a 16-entry store (wrap, IFG, abort, zero length, reset).
module tb_mii_packet_tx;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PRE   = 7;
    localparam int IFG   = 12;
`ifdef PKT_TX_FCS_EN
    localparam int FCSN = 4;
`else
    localparam int FCSN = 0;
`endif

    logic          iclk = 1'b0, i_rst = 1'b1, i_tx_enable = 1'b0, i_abort = 1'b0;
    logic          i_len_empty, o_len_rd, otx_en, o_busy, o_pkt_done;
    logic [AW-1:0] i_len, o_rd_addr, addr_s;
    logic [7:0]    i_rd_data, otx_d, d_s;
    logic          en_s, done_s, busy_s, rd_s;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    fcs_s [4];
    int            q[$];
    int            tests = 0, fails = 0, cyc = 0, pop_cyc = -1, done_cyc = -1, mark;

    always #5 iclk = ~iclk;
    assign i_rd_data = mem[o_rd_addr];

    mii_packet_tx #(.pDEPTH_RAM(DEPTH)) dut (
        .iclk(iclk), .i_rst(i_rst), .i_tx_enable(i_tx_enable), .i_abort(i_abort),
        .i_len(i_len), .i_len_empty(i_len_empty), .o_len_rd(o_len_rd), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .otx_en(otx_en), .otx_d(otx_d), .o_busy(o_busy), .o_pkt_done(o_pkt_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        i_len_empty = q.size() == 0;
        i_len       = (q.size() != 0) ? AW'(q[0]) : '0;
    endtask

    task automatic push(input int l);
        q.push_back(l);
        refresh();
    endtask

    task automatic tick();
        @(negedge iclk);
        en_s = otx_en; d_s = otx_d; addr_s = o_rd_addr; done_s = o_pkt_done; busy_s = o_busy; rd_s = o_len_rd;
        @(posedge iclk);
        #1;
        if (rd_s) begin
            pop_cyc = cyc;
            if (q.size() != 0) q.delete(0);
        end
        refresh();
        cyc++;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_pop(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_s) begin
                check({tag, " idle"}, 32'({en_s, done_s, busy_s}), 32'h0);
                return;
            end
        end
        check({tag, " pop timeout"}, 32'(rd_s), 32'h1);
    endtask

    task automatic expect_frame(input string tag, input int len, input int start, input int ab);
        wait_pop(tag);
        for (int k = 0; k < PRE; k++) begin
            tick();
            check({tag, " pre"}, 32'({en_s, d_s}), 32'h155);
        end
        tick();
        check({tag, " sfd"}, 32'({en_s, d_s}), 32'h1D5);
        check({tag, " addr0"}, 32'(addr_s), 32'(start));
        for (int k = 0; k < len; k++) begin
            if (k == ab) i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            check({tag, " byte"}, 32'({en_s, d_s}), 32'({1'b1, mem[(start + k) % DEPTH]}));
            check({tag, " addr"}, 32'(addr_s), 32'((start + k + 1) % DEPTH));
            if (k == ab) break;
        end
`ifdef PKT_TX_FCS_EN
        if (ab < 0) for (int k = 0; k < 4; k++) begin
            tick();
            check({tag, " fcs en"}, 32'(en_s), 32'h1);
            fcs_s[k] = d_s;
        end
`endif
        tick();
        check({tag, " end"}, 32'({en_s, done_s}), 32'h1);
        check({tag, " ptr"}, 32'(addr_s), 32'((start + len) % DEPTH));
        done_cyc = cyc - 1;
        tick();
        check({tag, " done pulse"}, 32'(done_s), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h11 * (i + 1));
        refresh();
        i_tx_enable = 1'b1;
        push(4);
        repeat (2) tick();
        check("rst outputs", 32'({en_s, d_s, addr_s, done_s, busy_s}), 32'h0);
        check("rst len_rd", 32'(rd_s), 32'h0);
        i_rst = 1'b0;

        expect_frame("t1", 4, 0, -1);
        check("t1 pop to done", 32'(done_cyc - pop_cyc), 32'(13 + FCSN));

        do_reset();
        push(3);
        push(5);
        expect_frame("t2a", 3, 0, -1);
        mark = done_cyc;
        expect_frame("t2b", 5, 3, -1);
        check("t2 gap", 32'(pop_cyc - mark + 1), 32'(IFG + 1));

        push(6);
        expect_frame("t3a", 6, 8, -1);
        push(4);
        expect_frame("t3b", 4, 14, -1);

        do_reset();
        push(10);
        expect_frame("t4", 10, 0, 1);
        push(2);
        expect_frame("t4b", 2, 10, -1);

        do_reset();
        push(0);
        push(1);
        wait_pop("t5z");
        mark = pop_cyc;
        expect_frame("t5", 1, 0, -1);
        check("t5 back to back pop", 32'(pop_cyc - mark), 32'h1);
        push(3);
        wait_pop("t5r");
        repeat (2) tick();
        push(2);
        i_rst = 1'b1;
        tick();
        tick();
        check("t5 rst outputs", 32'({en_s, d_s, addr_s, done_s, busy_s}), 32'h0);
        check("t5 rst len_rd", 32'(rd_s), 32'h0);
        i_rst = 1'b0;
        expect_frame("t5c", 2, 0, -1);

`ifdef PKT_TX_FCS_EN
        do_reset();
        for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
        push(9);
        expect_frame("t6", 9, 0, -1);
        check("t6 fcs", 32'({fcs_s[0], fcs_s[1], fcs_s[2], fcs_s[3]}), 32'h2639F4CB);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
